obstacle_scheduler: RTL

OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

---
 rtl/obstacle_scheduler.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/obstacle_scheduler.sv
// Obstacle slot scheduler for a side-scroller: per-frame scroll/retire of NSLOT
// obstacles, cooldown-gated spawning, speed ramp and a registered pixel overlay.
module obstacle_scheduler #(
  parameter int CIDXW     = 3,
  parameter int CORDW     = 10,
  parameter int NSLOT     = 4,
  parameter int SPAWN_GAP = 48,
  parameter int OBS_W     = 16,
  parameter int OBS_H     = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             frame_tick,
  input  logic             game_run,
  input  logic             game_clear,
  input  logic [12:0]      rand_val,
  input  logic [CORDW-1:0] hc,
  input  logic [CORDW-1:0] vc,
  output logic [CIDXW:0]   obstacle_pix,
  output logic [2:0]       speed_level,
  output logic [7:0]       pass_count,
  output logic [NSLOT-1:0] active_mask
);

  localparam int IW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int CW = CORDW + 1;
  localparam logic [CIDXW:0] PIX_ON = {1'b1, {CIDXW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_UPDATE = 2'd2,
    S_SPAWN  = 2'd3
  } state_t;

  state_t                      state_r, state_s;
  logic [IW-1:0]               idx_r;
  logic [NSLOT-1:0]            valid_r;
  logic [NSLOT-1:0][CORDW-1:0] x_r;
  logic [NSLOT-1:0][1:0]       lane_r;
  logic [7:0]                  cooldown_r;
  logic [2:0]                  speed_r;
  logic [7:0]                  pass_r;
  logic [CIDXW:0]              pix_r;

  logic             upd_en_s, spawn_en_s, free_found_s, hit_s;
  logic [CORDW-1:0] step_s, retire_lim_s;
  logic [7:0]       thresh_s, cool_inc_s, pass_inc_s;
  logic [IW-1:0]    free_idx_s;
  logic [1:0]       spawn_lane_s;

  function automatic logic [CORDW-1:0] lane_top(input logic [1:0] lane);
    case (lane)
      2'd1:    lane_top = CORDW'(160);
      2'd2:    lane_top = CORDW'(200);
      2'd3:    lane_top = CORDW'(250);
      default: lane_top = '0;
    endcase
  endfunction

  assign step_s       = CORDW'(speed_r) + CORDW'(1'b1);
  assign retire_lim_s = CORDW'(8'd170) + step_s;
  assign thresh_s     = 8'(SPAWN_GAP) - {3'b000, speed_r, 2'b00};
  assign cool_inc_s   = (cooldown_r == 8'hFF) ? 8'hFF : cooldown_r + 8'd1;
  assign pass_inc_s   = pass_r + 8'd1;
  assign free_found_s = ~&valid_r;
  assign spawn_lane_s = 2'(rand_val % 13'd3) + 2'd1;

  // Lowest-index free slot (descending scan so the lowest index wins)
  always_comb begin
    free_idx_s = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      free_idx_s = valid_r[i] ? free_idx_s : IW'(i);
    end
  end

  // Does any valid slot cover the current beam position
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      hit_s = hit_s | (valid_r[i]
        && ({1'b0, hc} >= {1'b0, x_r[i]})
        && ({1'b0, hc} <= {1'b0, x_r[i]} + CW'(OBS_W - 1))
        && ({1'b0, vc} >= {1'b0, lane_top(lane_r[i])})
        && ({1'b0, vc} <= {1'b0, lane_top(lane_r[i])} + CW'(OBS_H - 1)));
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // FSM next state: clear and pause override everything
  always_comb begin
    state_s = state_r;
    if (game_clear || !game_run) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:   state_s = S_WAIT;
        S_WAIT:   state_s = frame_tick ? S_UPDATE : S_WAIT;
        S_UPDATE: state_s = (idx_r == IW'(NSLOT - 1)) ? S_SPAWN : S_UPDATE;
        S_SPAWN:  state_s = S_WAIT;
        default:  state_s = S_IDLE;
      endcase
    end
  end

  // FSM outputs: datapath enables, frozen while paused or clearing
  always_comb begin
    upd_en_s   = 1'b0;
    spawn_en_s = 1'b0;
    if (game_run && !game_clear) begin
      case (state_r)
        S_UPDATE: upd_en_s   = 1'b1;
        S_SPAWN:  spawn_en_s = 1'b1;
        default: begin
          upd_en_s   = 1'b0;
          spawn_en_s = 1'b0;
        end
      endcase
    end else begin
      upd_en_s   = 1'b0;
      spawn_en_s = 1'b0;
    end
  end

  // Slot table, cooldown, pass counter and speed ramp
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_r    <= '0;
      x_r        <= '0;
      lane_r     <= '0;
      idx_r      <= '0;
      cooldown_r <= 8'd0;
      speed_r    <= 3'd0;
      pass_r     <= 8'd0;
    end else if (game_clear) begin
      valid_r    <= '0;
      x_r        <= '0;
      lane_r     <= '0;
      idx_r      <= '0;
      cooldown_r <= 8'd0;
      speed_r    <= 3'd0;
      pass_r     <= 8'd0;
    end else begin
      if (upd_en_s) begin
        idx_r <= (idx_r == IW'(NSLOT - 1)) ? '0 : idx_r + IW'(1);
        if (valid_r[idx_r]) begin
          if (x_r[idx_r] < retire_lim_s) begin
            valid_r[idx_r] <= 1'b0;
            pass_r         <= pass_inc_s;
            if ((pass_inc_s[2:0] == 3'd0) && (speed_r != 3'd7)) speed_r <= speed_r + 3'd1;
          end else begin
            x_r[idx_r] <= x_r[idx_r] - step_s;
          end
        end
      end else begin
        idx_r <= '0;
      end
      // A blocked spawn parks the cooldown at threshold so it retries every frame
      if (spawn_en_s) begin
        if ((cool_inc_s >= thresh_s) && free_found_s) begin
          valid_r[free_idx_s] <= 1'b1;
          x_r[free_idx_s]     <= CORDW'(750);
          lane_r[free_idx_s]  <= spawn_lane_s;
          cooldown_r          <= 8'd0;
        end else if ((cool_inc_s >= thresh_s) && (cooldown_r >= thresh_s)) begin
          cooldown_r <= cooldown_r;
        end else begin
          cooldown_r <= cool_inc_s;
        end
      end
    end
  end

  // Registered pixel colour
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) pix_r <= '0;
    else        pix_r <= (game_run && hit_s) ? PIX_ON : '0;
  end

  assign obstacle_pix = pix_r;
  assign speed_level  = speed_r;
  assign pass_count   = pass_r;
  assign active_mask  = valid_r;

endmodule
